// File: rtl/maf_pkg.sv
// Shared constants and helpers for the moving average filter.
//   MAF_W         : default signed sample width
//   MAF_LOG2_TAPS : default log2 of averaging depth
//   MAF_NUM_CH    : default channel count
//   maf_sum_width : running-sum width that can never overflow
`timescale 1ns/1ps
package maf_pkg;

    localparam int unsigned MAF_W         = 24;
    localparam int unsigned MAF_LOG2_TAPS = 3;
    localparam int unsigned MAF_NUM_CH    = 2;

    // Sum of 2**log2_taps samples of w bits needs log2_taps extra bits.
    function automatic int unsigned maf_sum_width(input int unsigned w,
                                                  input int unsigned log2_taps);
        return w + log2_taps;
    endfunction

endpackage

// File: rtl/maf_channel.sv
// One channel of the moving average filter: circular sample history,
// running sum and registered output.
// Ports:
//   clk, reset      : clock, async active-high reset
//   enable          : take a new sample this cycle
//   flush           : synchronous clear of history, sum and output
//   bypass          : output the raw sample instead of the average
//   wr_ptr          : shared history slot (holds the oldest sample)
//   sample          : new signed sample
//   avg             : registered filtered output
// Build option: define MAF_ROUND_EN to round half toward +inf instead of
// truncating toward -inf.
`timescale 1ns/1ps
module maf_channel
    import maf_pkg::*;
#(
    parameter int unsigned W         = MAF_W,
    parameter int unsigned LOG2_TAPS = MAF_LOG2_TAPS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   bypass,
    input  logic [LOG2_TAPS-1:0]   wr_ptr,
    input  logic signed [W-1:0]    sample,
    output logic signed [W-1:0]    avg
);

    localparam int unsigned TAPS = 1 << LOG2_TAPS;
    localparam int unsigned SW   = maf_sum_width(W, LOG2_TAPS);

    logic signed [W-1:0]  hist [TAPS];
    logic signed [SW-1:0] sum;

    logic signed [W-1:0]  oldest_c;
    logic signed [SW-1:0] sum_next_c;
    logic signed [SW-1:0] acc_c;
    logic signed [W-1:0]  avg_next_c;

    // Updated sum and its scaled value; all arithmetic at full sum width.
    always_comb begin
        oldest_c   = hist[wr_ptr];
        sum_next_c = sum + SW'(sample) - SW'(oldest_c);
`ifdef MAF_ROUND_EN
        acc_c      = sum_next_c + SW'(signed'(TAPS / 2));
`else
        acc_c      = sum_next_c;
`endif
        // The shifted sum always fits in W bits, so dropping the top is safe.
        avg_next_c = W'(acc_c >>> LOG2_TAPS);
    end

    // History, running sum and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                hist[LOG2_TAPS'(i)] <= '0;
            end
            sum <= '0;
            avg <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                hist[LOG2_TAPS'(i)] <= '0;
            end
            sum <= '0;
            avg <= '0;
        end else if (enable) begin
            hist[wr_ptr] <= sample;
            sum          <= sum_next_c;
            // History keeps updating under bypass so release is seamless.
            avg          <= bypass ? sample : avg_next_c;
        end
    end

endmodule

// File: rtl/moving_average_filter.sv
// Multi-channel boxcar moving average filter for audio samples.
// Averages the last 2**LOG2_TAPS samples of each channel independently.
// Ports:
//   clk, reset : clock, async active-high reset
//   enable     : sample strobe, one new sample per channel per high cycle
//   flush      : synchronous clear of history and sums (wins over enable)
//   bypass     : output raw input samples at the enable edge
//   data_in    : packed signed samples, channel k at [k*W +: W]
//   data_out   : packed signed filtered samples, same packing, registered
//   out_valid  : one-cycle pulse per accepted sample
// Build option: define MAF_ROUND_EN to round half toward +inf.
`timescale 1ns/1ps
module moving_average_filter
    import maf_pkg::*;
#(
    parameter int unsigned W         = MAF_W,
    parameter int unsigned LOG2_TAPS = MAF_LOG2_TAPS,
    parameter int unsigned NUM_CH    = MAF_NUM_CH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic                        bypass,
    input  logic signed [NUM_CH*W-1:0]  data_in,
    output logic signed [NUM_CH*W-1:0]  data_out,
    output logic                        out_valid
);

    logic [LOG2_TAPS-1:0] wr_ptr;

    // Shared write pointer (power-of-two depth wraps naturally) and valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= enable & ~flush;
            if (flush) begin
                wr_ptr <= '0;
            end else if (enable) begin
                wr_ptr <= wr_ptr + LOG2_TAPS'(1);
            end
        end
    end

    // One independent datapath per channel.
    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
        maf_channel #(
            .W         (W),
            .LOG2_TAPS (LOG2_TAPS)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .flush  (flush),
            .bypass (bypass),
            .wr_ptr (wr_ptr),
            .sample (data_in[k*W +: W]),
            .avg    (data_out[k*W +: W])
        );
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench for moving_average_filter (W=24, LOG2_TAPS=3, NUM_CH=2).
// A queue-based reference model predicts outputs; a compare process checks
// every cycle, and directed vectors pin hand-computed values.
`timescale 1ns/1ps
module tb_moving_average_filter;

    localparam int W         = 24;
    localparam int LOG2_TAPS = 3;
    localparam int NUM_CH    = 2;
    localparam int TAPS      = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic flush  = 1'b0;
    logic bypass = 1'b0;
    logic signed [NUM_CH*W-1:0] data_in = '0;
    logic signed [NUM_CH*W-1:0] data_out;
    logic                       out_valid;

    int errors = 0;
    int checks = 0;

    logic [NUM_CH*W-1:0] exp_data = '0;
    logic [NUM_CH*W-1:0] nxt_data = '0;
    logic                exp_valid = 1'b0;
    logic                nxt_valid = 1'b0;

    logic pin_req  = 1'b0;
    int   pin_val0 = 0;
    int   pin_val1 = 0;

    // Most recent sample at the front.
    int q [NUM_CH][$];

    always #5 clk = ~clk;

    moving_average_filter #(
        .W         (W),
        .LOG2_TAPS (LOG2_TAPS),
        .NUM_CH    (NUM_CH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .bypass    (bypass),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int model_avg(input int ch);
        longint s = 0;
        foreach (q[ch][i]) s += longint'(q[ch][i]);
`ifdef MAF_ROUND_EN
        s += longint'(TAPS / 2);
`endif
        return int'(floor_div(s, longint'(TAPS)));
    endfunction

    function automatic void model_clear();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            q[ch].delete();
            for (int i = 0; i < TAPS; i++) q[ch].push_back(0);
        end
    endfunction

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        int got0;
        int got1;
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid: got %0b expected %0b at %0t", out_valid, exp_valid, $time);
        end
        checks++;
        if (data_out !== exp_data) begin
            errors++;
            $display("FAIL data_out: got %h expected %h at %0t", data_out, exp_data, $time);
        end
        if (pin_req) begin
            got0 = int'($signed(data_out[0 +: W]));
            got1 = int'($signed(data_out[W +: W]));
            checks++;
            if (got0 != pin_val0) begin
                errors++;
                $display("FAIL pinned ch0: got %0d expected %0d at %0t", got0, pin_val0, $time);
            end
            checks++;
            if (got1 != pin_val1) begin
                errors++;
                $display("FAIL pinned ch1: got %0d expected %0d at %0t", got1, pin_val1, $time);
            end
        end
    end

    // Drive one cycle of inputs and advance the model to match.
    task automatic step(input logic en, input logic fl, input logic byp,
                        input int d0, input int d1);
        int d [NUM_CH];
        d[0] = d0;
        d[1] = d1;
        enable = en;
        flush  = fl;
        bypass = byp;
        for (int k = 0; k < NUM_CH; k++) data_in[k*W +: W] = W'(d[k]);
        nxt_valid = en && !fl;
        nxt_data  = exp_data;
        if (fl) begin
            model_clear();
            nxt_data = '0;
        end else if (en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                q[k].push_front(d[k]);
                void'(q[k].pop_back());
                nxt_data[k*W +: W] = byp ? W'(d[k]) : W'(model_avg(k));
            end
        end
        @(posedge clk);
        exp_data  = nxt_data;
        exp_valid = nxt_valid;
        #1;
    endtask

    // Hand-computed literal expectation for the current output.
    task automatic pin(input int v0, input int v1);
        pin_val0 = v0;
        pin_val1 = v1;
        pin_req  = 1'b1;
        @(negedge clk);
        #1;
        pin_req  = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        flush  = 1'b0;
        bypass = 1'b0;
        #1;
        model_clear();
        exp_data  = '0;
        exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        pin(0, 0);
        reset = 1'b0;

        // Impulse on ch0: eight outputs of 8, then 0; ch1 untouched
        step(1, 0, 0, 64, 0);
        pin(8, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        pin(8, 0);
        step(1, 0, 0, 0, 0);
        pin(0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Step of -16 on ch1 with idle cycles in between for hold
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 0, -16);
            pin(0, -2 * i);
            step(0, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, -16);
        pin(0, -16);

        // Rounding of a single +4 / -4
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 4, -4);
`ifdef MAF_ROUND_EN
        pin(1, 0);
`else
        pin(0, -1);
`endif
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
`ifdef MAF_ROUND_EN
        pin(0, 0);
`else
        pin(0, 0);
`endif

        // Full-scale extremes, no wrap
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8388607, -8388608);
        pin(8388607, -8388608);
        for (int i = 0; i < 8; i++) step(1, 0, 0, -8388608, 8388607);
        pin(-8388608, 8388607);

        // Flush together with enable at the fifth sample
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 40, 24);
        pin(20, 12);
        step(1, 1, 0, 5, 5);
        pin(0, 0);
        step(1, 0, 0, 80, 0);
        pin(10, 0);

        // Bypass, then release into a correct average
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 8, 1);
        pin(8, 1);
        step(1, 0, 1, 16, 2);
        pin(16, 2);
        step(1, 0, 1, 24, 3);
        pin(24, 3);
        step(1, 0, 0, 32, 2);
        pin(10, 1);

        // Reset mid-stream discards history
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1000, -1000);
        do_reset();
        step(1, 0, 0, 48, -48);
        pin(6, -6);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moving_average_filter.md
MOVING_AVERAGE_FILTER -- requirements
Module: moving_average_filter

Interface
REQ-001 SHALL have parameter W, default 24, meaning signed sample width in bits.
REQ-002 SHALL have parameter LOG2_TAPS, default 3, meaning averaging depth TAPS = 2**LOG2_TAPS (legal range 1..6).
REQ-003 SHALL have parameter NUM_CH, default 2, meaning number of independent audio channels.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  sample strobe (codec read_ready); one new sample per channel per high cycle.
REQ-007 SHALL have port flush  input  1  synchronous clear of history and sums.
REQ-008 SHALL have port bypass  input  1  when high, output is the raw input sample.
REQ-009 SHALL have port data_in  input  NUM_CH*W  packed signed samples; channel k at bits [k*W +: W].
REQ-010 SHALL have port data_out  output  NUM_CH*W  packed signed filtered samples, same packing.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse marking new data_out.

Function
REQ-012 SHALL keep, per channel, a circular history of TAPS samples plus a running sum of width W+LOG2_TAPS.
REQ-013 On enable: sum <= sum + new - oldest; oldest slot overwritten with new; shared write pointer advances.
REQ-014 Write pointer SHALL wrap from TAPS-1 to 0 with no extra cycle.
REQ-015 data_out SHALL be registered: (updated sum) >>> LOG2_TAPS, computed at full width, low W bits kept; never overflows.
REQ-016 Latency SHALL be 1 cycle: data_out and out_valid update on the edge that samples enable; out_valid is high exactly one cycle per enable.
REQ-017 data_out SHALL hold its value between enables.
REQ-018 After reset or flush, history is zero, so warm-up outputs average with zeros (no fill counter).
REQ-019 bypass high at an enable edge: data_out <= data_in; history and sums still update, so releasing bypass yields a correct average immediately.
REQ-020 flush and enable in the same cycle: flush wins; sample discarded, out_valid low, data_out <= 0.
REQ-021 Channels SHALL be fully independent; a value on one channel never affects another.

Reset
REQ-022 reset SHALL asynchronously clear history, sums, write pointer, data_out (0) and out_valid (0).
REQ-023 reset asserted mid-stream SHALL discard all history; first output after release equals new sample >>> LOG2_TAPS.

Configuration
REQ-024 Macro MAF_ROUND_EN defined: output = (sum + 2**(LOG2_TAPS-1)) >>> LOG2_TAPS (round half toward +inf).
REQ-025 MAF_ROUND_EN undefined: output = sum >>> LOG2_TAPS (arithmetic truncation toward -inf).

Structure
REQ-026 Package maf_pkg SHALL hold default W/LOG2_TAPS/NUM_CH constants and a helper function for sum width.
REQ-027 Sub-module maf_channel SHALL implement one channel (history, sum, output register), instantiated NUM_CH times via generate; top owns write pointer and out_valid.

Verification (W=24, LOG2_TAPS=3, NUM_CH=2)
REQ-028 Impulse: ch0 = 64 once then zeros, 10 enables -> ch0 out 8 for 8 outputs then 0; ch1 stays 0.
REQ-029 Step: ch1 = -16 constant -> outputs -2,-4,...,-16 then hold -16; out_valid pulses once per enable, data_out steady between.
REQ-030 Rounding: single 4 then zeros -> out 0 without MAF_ROUND_EN, 1 with it; single -4 -> -1 without, 0 with.
REQ-031 Extremes: 8 enables of 24'h7FFFFF then 8 of 24'h800000 -> outputs reach exactly 8388607 then -8388608, no wrap.
REQ-032 Flush with enable at sample 5 -> out_valid low, data_out 0; next input 80 -> out 10.
REQ-033 Bypass for 3 samples 8,16,24 then release with 32 -> outputs 8,16,24, then 10 (80/8).
